// File: rtl/input_credit_fifo_pkg.sv
// Shared sizing helpers and defaults for the input credit FIFO.
package input_credit_fifo_pkg;

  // Data word width on both the USB input side and the application read side.
  localparam int DATA_W = 16;

  // Outstanding-credit counter width; it holds grants up to DEPTH for the largest RAM.
  localparam int OUT_W = 17;

  // Default RAM address MSB (8192 words).
  localparam int ADDR_MSB_DEFAULT = 12;

  // Default upper clamp on a single grant.
  localparam logic [DATA_W-1:0] CREDIT_MAX_DEFAULT = 16'hFFFF;

  // MSB index for a vector of the given width.
  function automatic int msb(input int width);
    return width - 1;
  endfunction

  // RAM depth derived from the address MSB.
  function automatic int depth_of(input int addr_msb);
    return 1 << (addr_msb + 1);
  endfunction

endpackage

// File: rtl/input_credit_fifo_if.sv
// Handshake bundle between the USB input side / application and the FIFO.
interface input_credit_fifo_if;
  import input_credit_fifo_pkg::*;

  logic [msb(DATA_W):0] din;
  logic                 wr_en;
  logic                 full;
  logic [msb(DATA_W):0] dout;
  logic                 rd_en;
  logic                 empty;
  logic                 mode_credit;
  logic                 reg_input_credit;
  logic [msb(DATA_W):0] input_credit;
  logic                 credit_violation;

  // Side that writes/reads the FIFO and asks for credit.
  modport master (
    output din, wr_en, rd_en, mode_credit, reg_input_credit,
    input  full, dout, empty, input_credit, credit_violation
  );

  // The FIFO itself.
  modport slave (
    input  din, wr_en, rd_en, mode_credit, reg_input_credit,
    output full, dout, empty, input_credit, credit_violation
  );

endinterface

// File: rtl/input_credit_fifo_fwft_ram_stage.sv
// RAM, pointers and prefetch register presenting first-word-fall-through data.
module fwft_ram_stage
  import input_credit_fifo_pkg::*;
#(
  parameter int ADDR_MSB = ADDR_MSB_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [msb(DATA_W):0] din,
  input  logic                 rd_en,
  output logic [msb(DATA_W):0] dout,
  output logic                 empty,
  output logic [ADDR_MSB+1:0]  occ
);

  localparam int DEPTH = depth_of(ADDR_MSB);
  localparam int AW    = ADDR_MSB + 1;
  localparam int OW    = ADDR_MSB + 2;

  logic [msb(DATA_W):0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [OW-1:0]        occ_reg;
  logic                 valid_reg;
  logic [msb(DATA_W):0] dout_reg;
  logic                 rd_acc;
  logic                 load;
  logic [OW-1:0]        ram_cnt;

  // Occupancy includes the prefetch word; refill the output register whenever
  // it is empty or being consumed and the RAM still holds words.
  always_comb begin
    rd_acc  = rd_en & valid_reg;
    ram_cnt = occ_reg - OW'(valid_reg);
    load    = (ram_cnt != '0) & (~valid_reg | rd_acc);
  end

  // RAM write port; the caller only asserts wr for accepted writes.
  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr_reg] <= din;
  end

  // Registered RAM read straight into the output register.
  always_ff @(posedge CLK) begin
    if (rst) dout_reg <= '0;
    else if (load) dout_reg <= mem[rd_ptr_reg];
  end

  // Pointers, occupancy and output-valid bookkeeping.
  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      valid_reg  <= 1'b0;
    end else begin
      if (wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (load) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      occ_reg <= occ_reg + OW'(wr) - OW'(rd_acc);
      if (load) valid_reg <= 1'b1;
      else if (rd_acc) valid_reg <= 1'b0;
    end
  end

  assign dout  = dout_reg;
  assign empty = ~valid_reg;
  assign occ   = occ_reg;

endmodule

// File: rtl/input_credit_fifo.sv
// Host-to-FPGA input FIFO with optional credit gating of the write side.
module input_credit_fifo
  import input_credit_fifo_pkg::*;
#(
  parameter int                   ADDR_MSB   = ADDR_MSB_DEFAULT,
  parameter logic [msb(DATA_W):0] CREDIT_MAX = CREDIT_MAX_DEFAULT
) (
  input logic                CLK,
  input logic                rst,
  input_credit_fifo_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_MSB);
  localparam int OW    = ADDR_MSB + 2;

  logic [OW-1:0]        occ;
  logic [OUT_W-1:0]     out_reg;
  logic [OUT_W-1:0]     out_next;
  logic [OUT_W-1:0]     free;
  logic [OUT_W-1:0]     avail;
  logic [msb(DATA_W):0] grant;
  logic [msb(DATA_W):0] input_credit_reg;
  logic                 violation_reg;
  logic                 fifo_full;
  logic                 no_credit;
  logic                 wr_acc;

  // Acceptance and grant sizing, all from pre-edge state; a same-cycle read
  // is deliberately not counted as freeing space for the grant.
  always_comb begin
    fifo_full = (occ == OW'(DEPTH));
    no_credit = bus.mode_credit & (out_reg == '0);
    wr_acc    = bus.wr_en & ~fifo_full & ~no_credit & ~rst;
    free      = OUT_W'(DEPTH) - OUT_W'(occ);
    avail     = (free > out_reg) ? (free - out_reg) : '0;
    grant     = (avail > OUT_W'(CREDIT_MAX)) ? CREDIT_MAX : avail[msb(DATA_W):0];
    out_next  = '0;
    if (bus.mode_credit) begin
      out_next = out_reg;
      if (bus.reg_input_credit) out_next = out_next + OUT_W'(grant);
      if (wr_acc) out_next = out_next - OUT_W'(1);
    end
  end

  // Credit bookkeeping, last grant and the sticky violation flag.
  always_ff @(posedge CLK) begin
    if (rst) begin
      out_reg          <= '0;
      input_credit_reg <= '0;
      violation_reg    <= 1'b0;
    end else begin
      out_reg <= out_next;
      if (bus.reg_input_credit) input_credit_reg <= grant;
      if (bus.wr_en & no_credit) violation_reg <= 1'b1;
    end
  end

  fwft_ram_stage #(
    .ADDR_MSB(ADDR_MSB)
  ) u_stage (
    .CLK  (CLK),
    .rst  (rst),
    .wr   (wr_acc),
    .din  (bus.din),
    .rd_en(bus.rd_en),
    .dout (bus.dout),
    .empty(bus.empty),
    .occ  (occ)
  );

  assign bus.full             = fifo_full | no_credit;
  assign bus.input_credit     = input_credit_reg;
  assign bus.credit_violation = violation_reg;

endmodule

// File: tb/tb_input_credit_fifo.sv
// Scoreboard bench for input_credit_fifo at DEPTH=16.
module tb_input_credit_fifo;

  logic CLK = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] exp_q [$];

  always #5 CLK = ~CLK;

  input_credit_fifo_if bus();

  input_credit_fifo #(
    .ADDR_MSB  (3),
    .CREDIT_MAX(16'hFFFF)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, act, req);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  // One clock of stimulus; inputs change 2 time units after the active edge.
  task automatic cyc(input logic w, input logic [15:0] d, input logic r, input logic q);
    bus.wr_en = w;
    bus.din = d;
    bus.rd_en = r;
    bus.reg_input_credit = q;
    @(posedge CLK);
    #2;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.reg_input_credit = 1'b0;
  endtask

  task automatic do_reset(input logic mode);
    rst = 1'b1;
    bus.mode_credit = mode;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.reg_input_credit = 1'b1;
    bus.din = 16'hDEAD;
    @(posedge CLK);
    #2;
    exp_q.delete();
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.reg_input_credit = 1'b0;
  endtask

  // Monitor: a read handshake pending for the next edge pops one expected word.
  always @(negedge CLK) begin
    if (!rst && bus.rd_en && !bus.empty) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL rd_unexpected got=%0h want=none", bus.dout);
      end else begin
        chk("rd_data", 32'(bus.dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.din = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.mode_credit = 1'b0;
    bus.reg_input_credit = 1'b0;

    // Plain mode reset, with strobes asserted during reset
    do_reset(1'b0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full_plain", 32'(bus.full), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_credit", 32'(bus.input_credit), 0);
    chk("rst_viol", 32'(bus.credit_violation), 0);

    // Plain mode grant reports free space
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("plain_grant_empty", 32'(bus.input_credit), 16);

    // Fill 16 words
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 16'(i), 1'b0, 1'b0);
      exp_q.push_back(16'(i));
      if (i == 15) chk("plain_full_at15", 32'(bus.full), 0);
    end
    chk("plain_full_at16", 32'(bus.full), 1);
    cyc(1'b1, 16'h0011, 1'b0, 1'b0);
    chk("plain_full_after17", 32'(bus.full), 1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("plain_grant_full", 32'(bus.input_credit), 0);
    chk("plain_no_viol", 32'(bus.credit_violation), 0);

    // Drain 16 words back to back
    for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("plain_empty_after_drain", 32'(bus.empty), 1);
    chk("plain_all_read", 32'(exp_q.size()), 0);

    // FWFT latency into an empty FIFO
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    exp_q.push_back(16'hBEEF);
    chk("fwft_empty_edge_k", 32'(bus.empty), 1);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("fwft_empty_edge_k1", 32'(bus.empty), 0);
    chk("fwft_dout_edge_k1", 32'(bus.dout), 32'h0000BEEF);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("fwft_empty_after_rd", 32'(bus.empty), 1);

    // Credit mode: full until credit is granted
    do_reset(1'b1);
    chk("credit_rst_full", 32'(bus.full), 1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("credit_grant16", 32'(bus.input_credit), 16);
    chk("credit_full_after_grant", 32'(bus.full), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
      exp_q.push_back(16'(16'h0100 + i));
    end
    chk("credit_full_used", 32'(bus.full), 1);
    chk("credit_no_viol_yet", 32'(bus.credit_violation), 0);
    cyc(1'b1, 16'h01FF, 1'b0, 1'b0);
    chk("credit_viol_set", 32'(bus.credit_violation), 1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("credit_drained", 32'(exp_q.size()), 0);
    chk("credit_viol_sticky", 32'(bus.credit_violation), 1);

    // Partial grant
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("partial_grant16", 32'(bus.input_credit), 16);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
      exp_q.push_back(16'(16'h0200 + i));
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("partial_grant0", 32'(bus.input_credit), 0);
    chk("partial_not_full", 32'(bus.full), 0);

    // Re-grant after reads: occupancy 0, outstanding 11
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("regrant5", 32'(bus.input_credit), 5);

    // Build occupancy 5 with outstanding 3
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
      exp_q.push_back(16'(16'h0300 + i));
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);

    // Write + read + request together: free 11 - outstanding 3 = grant 8
    cyc(1'b1, 16'h03AA, 1'b1, 1'b1);
    exp_q.push_back(16'h03AA);
    chk("simul_grant8", 32'(bus.input_credit), 8);
    // Occupancy 5 + outstanding 10 leaves exactly one word
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("simul_followup_grant1", 32'(bus.input_credit), 1);

    // Reach occupancy 7, outstanding 4, then reset mid-operation
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 16'(16'h0400 + i), 1'b0, 1'b0);
      exp_q.push_back(16'(16'h0400 + i));
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("pre_rst_not_empty", 32'(bus.empty), 0);
    chk("pre_rst_viol", 32'(bus.credit_violation), 1);
    do_reset(1'b1);
    chk("midrst_empty", 32'(bus.empty), 1);
    chk("midrst_credit", 32'(bus.input_credit), 0);
    chk("midrst_full", 32'(bus.full), 1);
    chk("midrst_viol", 32'(bus.credit_violation), 0);

    // Write in the same cycle as the request, with no credit: dropped, violation
    cyc(1'b1, 16'h0555, 1'b0, 1'b1);
    chk("samecyc_viol", 32'(bus.credit_violation), 1);
    chk("samecyc_grant16", 32'(bus.input_credit), 16);
    chk("samecyc_not_full", 32'(bus.full), 0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("samecyc_dropped", 32'(bus.empty), 1);

    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_credit_fifo.md
Name: input_credit_fifo

Overview:
- Single-clock input FIFO on the host-to-FPGA path: 16-bit words from the USB input side are buffered and presented first-word-fall-through to the application read side.
- In credit mode the host must first request a credit. The block then grants the number of words it can accept and stops accepting once the granted words are used.
- Input-direction counterpart of the output-limit FIFO, with credit in place of limit.

Parameters:
- ADDR_MSB, 12, RAM address MSB; RAM depth DEPTH = 2^(ADDR_MSB+1) words (8192 words by default).
- CREDIT_MAX, 16'hFFFF, upper clamp on a single grant.

Ports:
- CLK  input  1  clock.
- rst  input  1  synchronous active-high reset.
- din  input  16  write data from the USB input side.
- wr_en  input  1  write strobe; ignored while full=1.
- full  output  1  write side cannot accept data.
- dout  output  16  FWFT read data; valid while empty=0.
- rd_en  input  1  pops the current word; ignored while empty=1.
- empty  output  1  no valid word on dout.
- mode_credit  input  1  1 enables credit gating; static during operation.
- reg_input_credit  input  1  one-cycle pulse requesting a new grant.
- input_credit  output  16  last granted word count; held until the next request.
- credit_violation  output  1  sticky; set when a write arrives with no credit outstanding.

Behaviour:
- Storage: DEPTH-word RAM, wr_ptr and rd_ptr of width ADDR_MSB+1, wrapping naturally at DEPTH, plus a 16-bit output (prefetch) register.
- Occupancy: a counter of width ADDR_MSB+2, range 0..DEPTH. It counts RAM words plus the output-register word.
- Write latency: a write accepted at edge k gives empty=0 with valid dout after edge k+1 when the FIFO was empty. Otherwise the word queues behind older data.
- Read: rd_en with empty=0 at edge k consumes dout. The next word, if present, is on dout after edge k+1 with empty=0 (no bubble). If none is present, empty=1.
- Simultaneous read and write: occupancy is unchanged.
- Write while full, or read while empty: no state change, no error.
- Outstanding-credit counter, 17 bits: granted but not yet written words.
- Credit grant on reg_input_credit=1 at edge k:
  - Inputs are the pre-edge values: free = DEPTH - occupancy; avail = free - outstanding, floored at 0.
  - grant = min(avail, CREDIT_MAX).
  - input_credit <= grant.
  - In credit mode: outstanding <= outstanding + grant - (accepted write this cycle ? 1 : 0).
  - A read in the same cycle does not enlarge the grant; this is conservative.
- Credit-mode rules (mode_credit=1):
  - full = (occupancy == DEPTH) | (outstanding == 0).
  - An accepted write decrements outstanding by 1.
  - A write attempt with outstanding == 0 is dropped and sets credit_violation.
  - A write with outstanding == 0 in the same cycle as reg_input_credit is still a violation, because it is evaluated against pre-edge state.
- Plain mode (mode_credit=0):
  - full = (occupancy == DEPTH).
  - reg_input_credit latches min(free, CREDIT_MAX) into input_credit.
  - outstanding stays 0; credit_violation is never set.
- Invariant: occupancy + outstanding <= DEPTH at all times.
- Reset (rst=1 at any edge, including mid-operation):
  - Pointers, occupancy and outstanding cleared to 0; input_credit = 0; credit_violation = 0.
  - empty = 1; dout = 0.
  - full = mode_credit after reset.
  - Data in flight is discarded.
  - reg_input_credit, wr_en and rd_en are ignored during the reset cycle.

Decomposition:
- Shared package or include: DEPTH derivation from ADDR_MSB, CREDIT_MAX default, and the MSB() width macro already used for FIFO sizing.
- One natural sub-module, fwft_ram_stage: the RAM, pointers and prefetch output register with FWFT read logic.
- Credit accounting and the violation flag stay in the top module.

Test Plan:
- Plain mode, ADDR_MSB=3 (DEPTH=16):
  - Write 0x0001..0x0010 -> full=1 after the 16th write; the 17th write is ignored.
  - Read 16 words -> exact order 0x0001..0x0010, then empty=1.
- FWFT latency: write 0xBEEF at edge k into an empty FIFO -> empty=0 and dout=0xBEEF after edge k+1.
- Credit mode, DEPTH=16, empty FIFO:
  - Pulse reg_input_credit -> input_credit=16, full=0.
  - Write 16 words -> full=1.
  - A 17th write -> dropped, credit_violation=1 and stays 1 until rst.
- Partial grant, credit mode, DEPTH=16: grant 16, write 5, pulse reg_input_credit again -> input_credit=0 (occupancy 5 + outstanding 11 = 16).
- Re-grant after reads: from the previous state, read 5 words, then pulse reg_input_credit -> input_credit=5.
- Simultaneous events: in one cycle, write (outstanding=3) + read + reg_input_credit -> outstanding becomes 2 + grant, where grant uses pre-edge free; occupancy unchanged.
- Mid-operation reset: assert rst with occupancy 7 and outstanding 4 -> next cycle empty=1, input_credit=0, full=1 (credit mode), credit_violation=0.
